inv_cipher_iter: RTL and testbench



---
 rtl/inv_cipher_pkg.sv | 73 +++++++
 rtl/inv_cipher_iter_inv_round.sv | 32 +++
 rtl/inv_cipher_iter.sv | 131 +++++++++++++
 tb/tb_inv_cipher_iter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/inv_cipher_pkg.sv
// Shared AES-128 inverse-cipher types, lookup tables, FSM encoding and GF(2^8) helpers.
package inv_cipher_pkg;

  localparam int NR = 10;
  localparam int NK = 4;
  localparam logic [3:0] LAST_KIDX = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  typedef logic [7:0]    byte_t;
  typedef byte_t [0:3]   word_t;
  typedef word_t [0:3]   state_t;

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} fsm_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_cipher_iter_inv_round.sv
// One combinational AES inverse round; last=1 drops InvMixColumns for the final round.
module inv_round
  import inv_cipher_pkg::*;
(
  input  state_t state,
  input  state_t rk,
  input  logic   last,
  output state_t result
);

  state_t t;
  state_t m;

  always_comb begin
    t = '0;
    m = '0;
    // InvShiftRows moves row r right by r columns, fused with InvSubBytes and AddRoundKey
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[c][r] = INV_SBOX[state[(c - r + 4) % 4][r]] ^ rk[c][r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        m[c][r] = gmul(t[c][r], 8'h0e) ^ gmul(t[c][(r + 1) % 4], 8'h0b)
                ^ gmul(t[c][(r + 2) % 4], 8'h0d) ^ gmul(t[c][(r + 3) % 4], 8'h09);
      end
    end
    result = last ? t : m;
  end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 decryptor: in-line key expansion then one inverse round per clock, 21 cycles accept->o_valid.
// Define INV_CIPHER_KEY_CACHE_EN to reuse the last expansion when the key repeats (11 cycles).
module inv_cipher_iter
  import inv_cipher_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t data,
  input  state_t key,
  output logic   o_valid,
  input  logic   o_ready,
  output state_t o,
  output logic   busy
);

  if (NR != 10 || NK != 4) begin : g_bad_cfg
    $error("inv_cipher_iter supports AES-128 only (NR=10, NK=4)");
  end

  fsm_t       state_q;
  fsm_t       state_d;
  state_t     st;
  state_t     rk [0:NR];
  state_t     rk_next;
  state_t     round_out;
  logic [3:0] kidx;
  logic [3:0] rnd;
  logic       accept;
  logic       key_hit;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign o_valid  = (state_q == DONE);
  assign accept   = (state_q == IDLE) && in_valid;

`ifdef INV_CIPHER_KEY_CACHE_EN
  logic   key_cached;
  state_t key_c;

  assign key_hit = key_cached && (key == key_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_cached <= 1'b0;
      key_c      <= '0;
    end else if (accept && !key_hit) begin
      key_cached <= 1'b0;
      key_c      <= key;
    end else if (state_q == KEXP && kidx == LAST_KIDX) begin
      key_cached <= 1'b1;
    end
  end
`else
  assign key_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = key_hit ? INIT : KEXP;
      KEXP:    if (kidx == LAST_KIDX) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (rnd == 4'd1) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIPS-197 expansion step: rk[kidx] from rk[kidx-1]
  always_comb begin
    logic [3:0] kprev;
    word_t      tw;
    byte_t      rc;
    state_t     prev;
    kprev   = (kidx == 4'd0) ? 4'd0 : kidx - 4'd1;
    rc      = (kidx >= 4'd1 && kidx <= LAST_KIDX) ? RCON[kidx] : 8'h00;
    prev    = rk[kprev];
    tw      = '0;
    rk_next = '0;
    for (int i = 0; i < 4; i++) tw[i] = SBOX[prev[3][(i + 1) % 4]];
    tw[0] = tw[0] ^ rc;
    rk_next[0] = prev[0] ^ tw;
    for (int i = 1; i < NK; i++) rk_next[i] = prev[i] ^ rk_next[i - 1];
  end

  inv_round u_inv_round (
    .state  (st),
    .rk     (rk[rnd]),
    .last   (state_q == FINAL),
    .result (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st      <= '0;
      o       <= '0;
      kidx    <= '0;
      rnd     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          st   <= data;
          kidx <= 4'd1;
        end
        KEXP:  kidx <= kidx + 4'd1;
        INIT: begin
          st  <= st ^ rk[NR];
          rnd <= FIRST_RND;
        end
        ROUND: begin
          st  <= round_out;
          rnd <= rnd - 4'd1;
        end
        FINAL:   o <= round_out;
        default: ;
      endcase
    end
  end

  // Round-key storage carries no reset; it is always rewritten before use
  always_ff @(posedge clk) begin
    if (accept) rk[0] <= key;
    if (state_q == KEXP) rk[kidx] <= rk_next;
  end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed bench for inv_cipher_iter: FIPS-197 vectors, latency, backpressure, ignored input, mid-run reset.
module tb_inv_cipher_iter;
  import inv_cipher_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  logic   o_ready = 1'b0;
  state_t data = '0;
  state_t key = '0;
  logic   in_ready;
  logic   o_valid;
  logic   busy;
  state_t o;

  int checks = 0;
  int failures = 0;
  int lat;

  localparam state_t K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam state_t P1   = 128'h00112233445566778899aabbccddeeff;
  localparam state_t K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam state_t C2   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam state_t P2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam state_t JUNK = 128'hdeadbeefcafef00d0123456789abcdef;
`ifdef INV_CIPHER_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  inv_cipher_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .key      (key),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o        (o),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one block, optionally pulses junk input pulse_at cycles after accept,
  // and returns the number of edges from accept until o_valid (capped at 100).
  task automatic run_block(input state_t ct, input state_t k, input int pulse_at, output int n);
    data = ct;
    key = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin
      if (n == pulse_at) begin
        in_valid = 1'b1;
        data = JUNK;
        key = JUNK;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_o_valid", 128'(o_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_o", o, '0);

    // C.1 with a junk pulse mid-run, then held backpressure
    run_block(C1, K1, 7, lat);
    chk("c1_latency", 128'(lat), 128'(21));
    chk("c1_plaintext", o, P1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_o_stable", o, P1);
      chk("bp_o_valid", 128'(o_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_busy", 128'(busy), 128'(1));
    end
    release_out();
    chk("rel_o_valid", 128'(o_valid), 128'(0));
    chk("rel_in_ready", 128'(in_ready), 128'(1));
    chk("rel_busy", 128'(busy), 128'(0));

    // FIPS-197 appendix B, new key
    run_block(C2, K2, -1, lat);
    chk("b_latency", 128'(lat), 128'(21));
    chk("b_plaintext", o, P2);
    release_out();

    // Abort with reset partway through, then a clean C.1
    data = C1;
    key = K1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_o_valid", 128'(o_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    run_block(C1, K1, -1, lat);
    chk("post_abort_latency", 128'(lat), 128'(21));
    chk("post_abort_plaintext", o, P1);
    release_out();

    // Same key again: reuses the expansion when caching is built in
    run_block(C1, K1, -1, lat);
    chk("repeat_key_latency", 128'(lat), 128'(HIT_LAT));
    chk("repeat_key_plaintext", o, P1);
    release_out();

    run_block(C2, K2, -1, lat);
    chk("key_change_latency", 128'(lat), 128'(21));
    chk("key_change_plaintext", o, P2);
    release_out();
    chk("final_idle", 128'(in_ready), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
